// File: rtl/tt_um_square_wave_meter.sv
// Two-channel square-wave half-period meter; reports the generator code (half-period - 1) per channel.
// Latency: input transition to code/valid/upd is 3 clocks, to the synchronised level bit 2 clocks.
// No backpressure: codes are free-running registers and upd is a single-cycle strobe.

module swm_channel (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sq_in,
    output logic [7:0] code,
    output logic       valid,
    output logic       upd,
    output logic       level
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        MEAS   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       s3_q, s3_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] code_q, code_d;
    logic [7:0] last_q, last_d;
    logic       valid_q, valid_d;
    logic       upd_q, upd_d;
    state_t     state_q, state_d;

    logic       edge_det;
    logic       close_match;
    logic [7:0] diff;

    // Either-polarity edge on the synchronised input.
    assign edge_det = s2_q ^ s3_q;

    // The +/-1 tolerance absorbs the one-cycle phase uncertainty of the synchroniser.
    assign diff        = (cnt_q >= last_q) ? (cnt_q - last_q) : (last_q - cnt_q);
    assign close_match = (diff <= 8'd1);

    // Next-state: synchroniser shift, edge-to-edge counter and lock state machine.
    always_comb begin
        s1_d    = sq_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        last_d  = last_q;
        state_d = state_q;
        upd_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (edge_det) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (edge_det) begin
                    state_d = MEAS;
                    last_d  = cnt_q;
                    code_d  = cnt_q;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd255) begin
                    state_d = IDLE;
                    code_d  = 8'd0;
                    last_d  = 8'd0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MEAS, LOCKED: begin
                if (edge_det) begin
                    state_d = close_match ? LOCKED : MEAS;
                    last_d  = cnt_q;
                    code_d  = cnt_q;
                    cnt_d   = 8'd0;
                    upd_d   = 1'b1;
                end else if (cnt_q == 8'd255) begin
                    state_d = IDLE;
                    code_d  = 8'd0;
                    last_d  = 8'd0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        valid_d = (state_d == LOCKED);
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= 8'd0;
            code_q  <= 8'd0;
            last_q  <= 8'd0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            state_q <= state_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign upd   = upd_q;
    assign level = s2_q;

endmodule

module tt_um_square_wave_meter (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [7:0] code_a, code_b;
    logic       valid_a, valid_b;
    logic       upd_a, upd_b;
    logic       level_a, level_b;
    logic       unused_ok;

    swm_channel u_ch_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sq_in (ui_in[0]),
        .code  (code_a),
        .valid (valid_a),
        .upd   (upd_a),
        .level (level_a)
    );

    swm_channel u_ch_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sq_in (ui_in[1]),
        .code  (code_b),
        .valid (valid_b),
        .upd   (upd_b),
        .level (level_b)
    );

    // Display select is a plain mux over registered codes, so it follows sel in the same cycle.
    assign uo_out  = ui_in[2] ? code_b : code_a;
    assign uio_out = {2'b00, level_b, level_a, upd_b, upd_a, valid_b, valid_a};
    assign uio_oe  = 8'hFF;

    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_square_wave_meter.sv
module tb_tt_um_square_wave_meter;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    logic       a, b, sel;
    logic [4:0] junk;
    int         ha, hb, ca, cb;
    logic       alt_a, sel_tog;
    logic       tog_a, upd_a_now;

    int n_tests, n_fail;
    int upd_a_cnt, upd_b_cnt, va_hi, va_lo, vb_hi;
    int n19, n20, noth;

    assign ui_in = {junk, sel, b, a};

    tt_um_square_wave_meter dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        upd_a_cnt = 0; upd_b_cnt = 0; va_hi = 0; va_lo = 0; vb_hi = 0;
        n19 = 0; n20 = 0; noth = 0;
    endtask

    // One clock: sample just after the edge, then advance the wave generators.
    task automatic step();
        @(posedge clk);
        #1;
        tog_a     = 1'b0;
        upd_a_now = uio_out[2];
        if (uio_out[2]) upd_a_cnt++;
        if (uio_out[3]) upd_b_cnt++;
        if (uio_out[0]) va_hi++; else va_lo++;
        if (uio_out[1]) vb_hi++;
        if (uio_out[2] && !sel) begin
            if (uo_out == 8'd19) n19++;
            else if (uo_out == 8'd20) n20++;
            else noth++;
        end
        if (ha != 0) begin
            ca++;
            if (ca >= ha) begin
                ca    = 0;
                a     = ~a;
                tog_a = 1'b1;
                if (alt_a) ha = (ha == 20) ? 21 : 20;
            end
        end
        if (hb != 0) begin
            cb++;
            if (cb >= hb) begin
                cb = 0;
                b  = ~b;
            end
        end
        if (sel_tog) sel = ~sel;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_toggle_a(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!tog_a && k < budget);
        chk("wait_toggle_a", tog_a, 1);
    endtask

    task automatic wait_upd_a(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!upd_a_now && k < budget);
        chk("wait_upd_a", upd_a_now, 1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        a = 0; b = 0; sel = 0; junk = 0;
        ha = 0; hb = 0; ca = 0; cb = 0;
        alt_a = 0; sel_tog = 0; tog_a = 0; upd_a_now = 0;
        uio_in = 8'h00; ena = 1'b1;
        clr_stats();
        rst_n = 1'b0;

        // Reset state
        run(3);
        chk("rst_uo_out", uo_out, 0);
        chk("rst_uio_out", uio_out, 0);
        chk("rst_uio_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;

        // Channel A, half-period 11 -> code 10
        ha = 11; sel = 0;
        run(100);
        chk("a11_valid", uio_out[0], 1);
        chk("a11_code", uo_out, 10);
        chk("a11_validB", uio_out[1], 0);
        clr_stats();
        run(110);
        chk("a11_upd_per_110", upd_a_cnt, 10);
        chk("a11_valid_drops", va_lo, 0);
        chk("a11_updB", upd_b_cnt, 0);

        // Input stops: timeout exactly 256 clocks after last processed edge
        wait_toggle_a(40);
        ha = 0; ca = 0;
        run(258);
        chk("to_valid_before", uio_out[0], 1);
        chk("to_code_before", uo_out, 10);
        chk("to_level_a", uio_out[4], a);
        run(1);
        chk("to_valid_after", uio_out[0], 0);
        chk("to_code_after", uo_out, 0);

        // Restart relocks
        ha = 11;
        run(60);
        chk("restart_valid", uio_out[0], 1);
        chk("restart_code", uo_out, 10);

        // Alternating 20/21: stays locked, codes 19/20
        ha = 20; alt_a = 1;
        run(200);
        clr_stats();
        run(410);
        chk("alt_valid_drops", va_lo, 0);
        chk("alt_n19", n19, 10);
        chk("alt_n20", n20, 10);
        chk("alt_other", noth, 0);

        // Switch to 40: unlock on first long edge, relock on next
        wait_toggle_a(40);
        ha = 40; alt_a = 0; ca = 0;
        run(5);
        wait_upd_a(60);
        chk("h40_first_valid", uio_out[0], 0);
        chk("h40_first_code", uo_out, 39);
        wait_upd_a(60);
        chk("h40_relock_valid", uio_out[0], 1);
        chk("h40_relock_code", uo_out, 39);

        // Channel B half-period 256 -> code 255
        hb = 256; sel = 1;
        run(1100);
        chk("b256_valid", uio_out[1], 1);
        chk("b256_code", uo_out, 255);
        chk("b256_validA", uio_out[0], 1);

        // Channel B half-period 257 -> times out every half-period
        hb = 257;
        run(600);
        clr_stats();
        run(1500);
        chk("b257_valid_hi", vb_hi, 0);
        chk("b257_updB", upd_b_cnt, 0);
        chk("b257_code", uo_out, 0);

        // Both channels, sel toggling
        ha = 5; hb = 100; sel_tog = 1;
        run(800);
        chk("both_validA", uio_out[0], 1);
        chk("both_validB", uio_out[1], 1);
        sel_tog = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            sel = 0;
            #1;
            chk("mux_sel0", uo_out, 4);
            sel = 1;
            #1;
            chk("mux_sel1", uo_out, 99);
        end

        // Asynchronous reset mid-run
        @(posedge clk);
        #3;
        junk = 5'($urandom);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_uo_out", uo_out, 0);
        chk("mid_rst_uio_out", uio_out, 0);
        chk("mid_rst_uio_oe", uio_oe, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            junk = 5'($urandom);
            a = 1'($urandom);
            b = 1'($urandom);
            step();
        end
        chk("hold_rst_uo_out", uo_out, 0);
        chk("hold_rst_uio_out", uio_out, 0);
        rst_n = 1'b1;
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
